// File: rtl/detector_delay_line_pkg.sv
// Shared definitions for the detector driver blocks.
//   clog2()             - ceiling log2 with a minimum of 1, for sizing ports
//   DETECTOR_DATA_WIDTH - default pixel width across the detector video path
//   dly_action_e        - what the delay line does on a given clock
package detector_delay_line_pkg;

    localparam int DETECTOR_DATA_WIDTH = 16;

    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ACT_HOLD,     // ce low: every register keeps its value
        ACT_SHIFT,    // ce high: write one sample, advance the line
        ACT_RESTART   // flush or cfg_load: restart priming
    } dly_action_e;

endpackage

// File: rtl/detector_delay_line_if.sv
// Video-path bundle for detector_delay_line.
//   master: drives ce, flush, cfg_delay, cfg_load, din_valid, din;
//           observes dout_valid, dout, filling, cfg_err
//   slave : the delay line itself (opposite directions)
interface detector_delay_line_if
    import detector_delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = DETECTOR_DATA_WIDTH,
    parameter int NUM_CH     = 1,
    parameter int MAX_DELAY  = 64
) ();
    localparam int DLY_W = clog2(MAX_DELAY + 1);

    logic                         ce;
    logic                         flush;
    logic [DLY_W-1:0]             cfg_delay;
    logic                         cfg_load;
    logic                         din_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] din;
    logic                         dout_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] dout;
    logic                         filling;
    logic                         cfg_err;

    modport master (
        output ce, flush, cfg_delay, cfg_load, din_valid, din,
        input  dout_valid, dout, filling, cfg_err
    );

    modport slave (
        input  ce, flush, cfg_delay, cfg_load, din_valid, din,
        output dout_valid, dout, filling, cfg_err
    );
endinterface

// File: rtl/detector_delay_ram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
//   clk              - write clock
//   wr_en/addr/data  - write port
//   rd_addr/rd_data  - read port (combinational)
module detector_delay_ram #(
    parameter int WIDTH  = 17,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; a reset term would stop it mapping
    // onto RAM. Priming guarantees no unwritten word ever reaches dout.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/detector_delay_line.sv
// Runtime-programmable, clock-enable-aware, multi-channel delay line built on
// a circular buffer. A sample offered on a ce cycle appears on dout after the
// D-th ce edge counted from its own.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of detector_delay_line_if (data, qualifiers, config)
module detector_delay_line
    import detector_delay_line_pkg::*;
#(
    parameter int DATA_WIDTH = DETECTOR_DATA_WIDTH,
    parameter int NUM_CH     = 1,
    parameter int MAX_DELAY  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    detector_delay_line_if.slave  bus
);
    localparam int DW     = NUM_CH * DATA_WIDTH;
    localparam int WORD_W = DW + 1;
    localparam int DLY_W  = clog2(MAX_DELAY + 1);
    localparam int PTR_W  = clog2(MAX_DELAY);

    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [DLY_W-1:0] DLY_MAX  = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W:0]   EXT_MAX  = (DLY_W + 1)'(MAX_DELAY);
    localparam logic [DLY_W:0]   EXT_ONE  = (DLY_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_DELAY - 1);

    logic [DLY_W-1:0]  delay_q, delay_d;
    logic [DLY_W-1:0]  fill_q, fill_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              cfg_err_q, cfg_err_d;

    logic [DLY_W-1:0]  delay_m1;
    logic [DLY_W:0]    rd_sum;
    logic [PTR_W-1:0]  rd_addr;
    logic [WORD_W-1:0] ram_rd_data;
    logic [WORD_W-1:0] rd_word;
    logic              wr_en;
    dly_action_e       action;

    assign delay_m1 = delay_q - DLY_ONE;

    // Read slot is D-1 writes behind wr_ptr, modulo the buffer depth. The RAM
    // read is combinational and dout_q captures it on the same edge as the
    // write; the two addresses differ whenever D >= 2, so this behaves as a
    // read-old RAM with dout_q as its registered read stage.
    always_comb begin
        // NOTE: combinational blocks use blocking '='; only always_ff uses '<='.
        rd_sum = (DLY_W + 1)'(wr_ptr_q) + EXT_MAX + EXT_ONE - {1'b0, delay_q};
        if (rd_sum >= EXT_MAX) rd_sum = rd_sum - EXT_MAX;
        rd_addr = rd_sum[PTR_W-1:0];
    end

    detector_delay_ram #(
        .WIDTH (WORD_W),
        .DEPTH (MAX_DELAY),
        .ADDR_W(PTR_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_q),
        .wr_data({bus.din_valid, bus.din}),
        .rd_addr(rd_addr),
        .rd_data(ram_rd_data)
    );

    // D=1 has nothing to store: the incoming sample is registered directly.
    assign rd_word = (delay_q == DLY_ONE) ? {bus.din_valid, bus.din} : ram_rd_data;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave one unassigned and infer a latch.
        delay_d      = delay_q;
        fill_d       = fill_q;
        wr_ptr_d     = wr_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        cfg_err_d    = cfg_err_q;
        wr_en        = 1'b0;

        if (bus.cfg_load || bus.flush) action = ACT_RESTART;
        else if (bus.ce)               action = ACT_SHIFT;
        else                           action = ACT_HOLD;

        unique case (action)
            ACT_RESTART: begin
                fill_d       = '0;
                dout_d       = '0;
                dout_valid_d = 1'b0;
                if (bus.cfg_load) begin
                    if (bus.cfg_delay == '0) begin
                        delay_d   = DLY_ONE;
                        cfg_err_d = 1'b1;
                    end else if (bus.cfg_delay > DLY_MAX) begin
                        delay_d   = DLY_MAX;
                        cfg_err_d = 1'b1;
                    end else begin
                        delay_d   = bus.cfg_delay;
                    end
                end
            end
            ACT_SHIFT: begin
                wr_en    = 1'b1;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
                if (fill_q < delay_m1) fill_d = fill_q + DLY_ONE;
                if (fill_q >= delay_m1) begin
                    {dout_valid_d, dout_d} = rd_word;
                end else begin
                    dout_d       = '0;
                    dout_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q      <= DLY_W'(2);
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            delay_q      <= delay_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.filling    = fill_q < delay_m1;
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: doc/detector_delay_line.md
Name: detector_delay_line

Overview:
- Runtime-programmable, multi-channel, clock-enable-aware delay line for the detector driver video path.
- Aligns pixel data and qualifiers across pipeline branches whose latency is only known at configuration time.
- Storage is a circular buffer in a simple dual-port RAM, not a register chain; delay changes without resynthesis.
- With ce=1 and delay=2, cycle behaviour matches a two-stage reset-to-zero register pipe.

Parameters:
- DATA_WIDTH, 16, bits per channel.
- NUM_CH, 1, number of parallel channels sharing one delay.
- MAX_DELAY, 64, largest supported delay in ce events; must be >= 2.
- DLY_W, clog2(MAX_DELAY+1), width of the cfg_delay port (localparam-derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- ce  in  1  pixel clock enable; all state advances only when ce=1.
- flush  in  1  sync pulse; restarts priming, keeps current delay.
- cfg_delay  in  DLY_W  requested delay in ce events.
- cfg_load  in  1  sync pulse; latch cfg_delay and restart priming.
- din_valid  in  1  qualifier travelling with din.
- din  in  NUM_CH*DATA_WIDTH  channel 0 in LSBs.
- dout_valid  out  1  delayed din_valid, gated by primed.
- dout  out  NUM_CH*DATA_WIDTH  delayed din, zero while not primed.
- filling  out  1  high while priming is incomplete.
- cfg_err  out  1  sticky; set on an out-of-range cfg_delay load.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset state: dout=0, dout_valid=0, filling=1, cfg_err=0, wr_ptr=0, fill_cnt=0, active delay D=2.
- RAM contents are not reset.
- Delay semantics: the value presented on a ce cycle appears on dout after the D-th ce edge counted from its own.
  - With ce=1 constantly, latency is D clk cycles.
- Range rules on cfg_load:
  - cfg_delay=0 is clamped to D=1.
  - cfg_delay>MAX_DELAY is clamped to MAX_DELAY.
  - Either clamp sets cfg_err; cfg_err clears only on reset.
- Datapath on a ce cycle with no flush and no cfg_load:
  - Write {din_valid,din} to mem[wr_ptr]; wr_ptr <= wr_ptr+1, wrapping MAX_DELAY-1 -> 0.
  - Read from mem[(wr_ptr-(D-1)) mod MAX_DELAY] when D>=2; D=1 bypasses the RAM and registers din directly.
  - fill_cnt saturates at D-1.
  - If the pre-increment fill_cnt >= D-1: dout and dout_valid load from the read word.
  - Otherwise dout <= 0 and dout_valid <= 0.
- filling = (fill_cnt < D-1) | (D-1 == 0 ? 0 : 0) [combinational compare on registered state; 0 when D=1].
- ce=0: all registers hold, including dout and dout_valid. Outputs are not pulses; consumers qualify with ce.
- flush or cfg_load cycle:
  - fill_cnt <= 0; dout <= 0; dout_valid <= 0.
  - Any sample offered that cycle is discarded; wr_ptr unchanged.
  - These take effect regardless of ce.
- flush and cfg_load together: cfg_load semantics apply (delay latched, priming restarted).
- Reset mid-operation: immediate return to the reset state; the new priming takes D ce events.
- The RAM read address is combinational from registered state. The RAM must support a registered read that meets the same-cycle requirement: the read is issued one ce early, or a write-first/read-old RAM is used. Implementation choice; the bench checks only the port behaviour.

Decomposition:
- Shared header: clog2 function and DETECTOR_DATA_WIDTH default, reused across detector_driver blocks.
- Sub-module: detector_delay_ram, a simple dual-port RAM of (NUM_CH*DATA_WIDTH+1) x MAX_DELAY with one write port and one read port.

Test Plan:
- Reset, ce=1, D=2, din=1,2,3… with valid=1 -> dout=0 on the first edge, dout=1 after the 2nd edge, then 2,3…; dout_valid rises with dout=1.
- cfg_load with cfg_delay=5, ce toggling 1,0,1,0… -> dout=first sample after the 5th ce edge; values hold during ce=0; filling clears after 4 ce events.
- cfg_delay=0 -> D=1, cfg_err=1, dout = din registered one ce later; cfg_delay=MAX_DELAY+3 -> D=MAX_DELAY, cfg_err stays 1.
- Run D=MAX_DELAY for 3*MAX_DELAY samples -> no data corruption across wr_ptr wrap; dout equals the sample from MAX_DELAY ce events earlier.
- flush mid-stream at D=4 -> dout=0 and dout_valid=0 for the next 3 ce events, then resumes with the first post-flush sample; din_valid=0 gaps reproduce on dout_valid exactly 4 ce later.
- NUM_CH=3, distinct per-channel ramps, plus rst_n asserted mid-stream -> channels stay aligned; all outputs are 0 immediately on rst_n low; recovery follows the first scenario.
